microcode_store: RTL and testbench

MICROCODE_STORE -- requirements
Module: microcode_store

---
 rtl/microcode_store.sv | 167 ++++++++++++++++
 tb/tb_microcode_store.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_store.sv
// Writable microcode control store: byte-serial loader assembling little-endian words,
// plus a registered single-port read path that the sequencer may use while no load is active.
module microcode_store #(
  parameter int WIDTH = 64,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [AW-1:0]     ld_base,
  input  logic [AW:0]       ld_count,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [7:0]        ld_sum
);

  localparam int BYTES = WIDTH / 8;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]    DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr_r;
  logic [AW:0]      remain_r;
  logic [BIW-1:0]   byte_idx_r;
  logic [WIDTH-1:0] word_r;
  logic [7:0]       sum_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             ld_ready_r, ld_busy_r, ld_done_r, ld_err_r;
  logic             legal_s, start_s, accept_s, err_s, last_byte_s, rd_fire_s;

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign ld_ready = ld_ready_r;
  assign ld_busy  = ld_busy_r;
  assign ld_done  = ld_done_r;
  assign ld_err   = ld_err_r;
  assign ld_sum   = sum_r;

  // Next-state decode and load/read qualifiers
  always_comb begin
    state_s     = state_r;
    err_s       = 1'b0;
    accept_s    = 1'b0;
    start_s     = 1'b0;
    legal_s     = (ld_count != (AW+1)'(0)) && (ld_count <= DEPTH_C);
    last_byte_s = (byte_idx_r == LAST_IDX);
    rd_fire_s   = rd_en && (state_r == IDLE);
    case (state_r)
      IDLE: begin
        if (ld_start) begin
          if (legal_s) begin
            start_s = 1'b1;
            state_s = LOAD;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          accept_s = 1'b1;
          if (last_byte_s) begin
            state_s = WRITE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      WRITE: begin
        // remain_r still counts the word being written this cycle
        if (remain_r > (AW+1)'(1)) begin
          state_s = LOAD;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Load datapath: address/count capture, byte packing and running checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= AW'(0);
      remain_r   <= (AW+1)'(0);
      byte_idx_r <= BIW'(0);
      word_r     <= WIDTH'(0);
      sum_r      <= 8'h00;
    end else if (start_s) begin
      addr_r     <= ld_base;
      remain_r   <= ld_count;
      byte_idx_r <= BIW'(0);
      sum_r      <= 8'h00;
    end else if (accept_s) begin
      word_r[8*byte_idx_r +: 8] <= ld_byte;
      sum_r                     <= sum_r + ld_byte;
      byte_idx_r                <= last_byte_s ? BIW'(0) : byte_idx_r + BIW'(1);
    end else if (state_r == WRITE) begin
      addr_r   <= addr_r + AW'(1);
      remain_r <= remain_r - (AW+1)'(1);
    end
  end

  // Status flags registered from the upcoming state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ready_r <= 1'b0;
      ld_busy_r  <= 1'b0;
      ld_done_r  <= 1'b0;
      ld_err_r   <= 1'b0;
    end else begin
      ld_ready_r <= (state_s == LOAD);
      ld_busy_r  <= (state_s != IDLE);
      ld_done_r  <= (state_s == DONE);
      ld_err_r   <= err_s;
    end
  end

  // Control-store array; contents survive reset by design
  always_ff @(posedge clk) begin
    if ((state_r == WRITE) && !rst) begin
      mem[addr_r] <= word_r;
    end
  end

  // Registered read port, locked out while a load is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= WIDTH'(0);
      rd_valid_r <= 1'b0;
    end else if (rd_fire_s) begin
      rd_data_r  <= mem[rd_addr];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_microcode_store.sv
// Directed bench for microcode_store (WIDTH=64, AW=9): loads, wrap, illegal counts,
// read lockout, reset mid-load and stalled loads against hand-computed words and sums.
module tb_microcode_store;

  logic        clk, rst, rd_en, ld_start, ld_valid;
  logic [8:0]  rd_addr, ld_base;
  logic [9:0]  ld_count;
  logic [7:0]  ld_byte, ld_sum;
  logic [63:0] rd_data;
  logic        rd_valid, ld_ready, ld_busy, ld_done, ld_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] tb_bytes [64];

  microcode_store #(.WIDTH(64), .AW(9)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err), .ld_sum(ld_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [8:0] base, input logic [9:0] count);
    ld_start = 1'b1; ld_base = base; ld_count = count;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps, output bit to);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < n && cyc < 2000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_byte  = tb_bytes[idx];
      end
      rdy = ld_ready;
      tick();
      if (ld_valid && rdy) idx++;
      cyc++;
    end
    ld_valid = 1'b0;
    to = (idx < n);
  endtask

  task automatic wait_idle(output int done_cnt, output bit to);
    int cyc = 0;
    done_cnt = 0;
    while (ld_busy && cyc < 100) begin
      tick();
      if (ld_done) done_cnt++;
      cyc++;
    end
    to = ld_busy;
  endtask

  task automatic rd(input logic [8:0] addr, output logic [63:0] data, output logic valid);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    data = rd_data; valid = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL reset_ld_busy got=%b exp=0", ld_busy); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL reset_ld_err got=%b exp=0", ld_err); end
    checks++; if (ld_sum !== 8'h00) begin failures++; $display("FAIL reset_ld_sum got=%h exp=00", ld_sum); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    bit to; int dc; logic [63:0] d; logic v;
    for (int i = 0; i < 16; i++) tb_bytes[i] = 8'(i + 1);
    start_load(9'h010, 10'd2);
    checks++; if (ld_busy !== 1'b1 || ld_ready !== 1'b1) begin failures++; $display("FAIL basic_enter_load busy=%b ready=%b exp=1/1", ld_busy, ld_ready); end
    feed(16, 1'b0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_feed_timeout got=%b exp=0", to); end
    checks++; if (ld_ready !== 1'b0 || ld_busy !== 1'b1) begin failures++; $display("FAIL basic_write_state ready=%b busy=%b exp=0/1", ld_ready, ld_busy); end
    wait_idle(dc, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_idle_timeout got=%b exp=0", to); end
    checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", dc); end
    checks++; if (ld_sum !== 8'h88) begin failures++; $display("FAIL basic_ld_sum got=%h exp=88", ld_sum); end
    rd(9'h010, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h0807060504030201) begin failures++; $display("FAIL basic_rd_010 valid=%b data=%h exp=1/0807060504030201", v, d); end
    rd(9'h011, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h100F0E0D0C0B0A09) begin failures++; $display("FAIL basic_rd_011 valid=%b data=%h exp=1/100f0e0d0c0b0a09", v, d); end
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h100F0E0D0C0B0A09) begin failures++; $display("FAIL basic_rd_hold valid=%b data=%h exp=0/100f0e0d0c0b0a09", rd_valid, rd_data); end
  endtask

  task automatic test_wrap();
    bit to; int dc; logic [63:0] d; logic v;
    for (int i = 0; i < 16; i++) tb_bytes[i] = 8'(8'hA0 + i);
    start_load(9'h1FF, 10'd2);
    feed(16, 1'b0, to);
    wait_idle(dc, to);
    checks++; if (to !== 1'b0 || dc !== 1) begin failures++; $display("FAIL wrap_done to=%b pulses=%0d exp=0/1", to, dc); end
    checks++; if (ld_sum !== 8'h78) begin failures++; $display("FAIL wrap_ld_sum got=%h exp=78", ld_sum); end
    rd(9'h1FF, d, v);
    checks++; if (v !== 1'b1 || d !== 64'hA7A6A5A4A3A2A1A0) begin failures++; $display("FAIL wrap_rd_1ff valid=%b data=%h exp=1/a7a6a5a4a3a2a1a0", v, d); end
    rd(9'h000, d, v);
    checks++; if (v !== 1'b1 || d !== 64'hAFAEADACABAAA9A8) begin failures++; $display("FAIL wrap_rd_000 valid=%b data=%h exp=1/afaeadacabaaa9a8", v, d); end
  endtask

  task automatic test_illegal_count();
    logic [63:0] d; logic v;
    logic [9:0] bad [2];
    bad[0] = 10'd0; bad[1] = 10'd513;
    for (int k = 0; k < 2; k++) begin
      start_load(9'h010, bad[k]);
      checks++; if (ld_err !== 1'b1 || ld_busy !== 1'b0) begin failures++; $display("FAIL illegal_err_%0d err=%b busy=%b exp=1/0", k, ld_err, ld_busy); end
      tick();
      checks++; if (ld_err !== 1'b0 || ld_busy !== 1'b0) begin failures++; $display("FAIL illegal_after_%0d err=%b busy=%b exp=0/0", k, ld_err, ld_busy); end
    end
    checks++; if (ld_sum !== 8'h78) begin failures++; $display("FAIL illegal_ld_sum got=%h exp=78", ld_sum); end
    rd(9'h010, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h0807060504030201) begin failures++; $display("FAIL illegal_mem_010 valid=%b data=%h exp=1/0807060504030201", v, d); end
  endtask

  task automatic test_read_during_load();
    bit to; int dc; logic [63:0] d; logic v;
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(8'h50 + i);
    rd(9'h010, d, v);
    rd_en = 1'b1; rd_addr = 9'h011;
    start_load(9'h030, 10'd1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h100F0E0D0C0B0A09 || ld_busy !== 1'b1) begin failures++; $display("FAIL rd_with_start valid=%b data=%h busy=%b exp=1/100f0e0d0c0b0a09/1", rd_valid, rd_data, ld_busy); end
    rd_addr = 9'h010;
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h100F0E0D0C0B0A09) begin failures++; $display("FAIL rd_while_busy valid=%b data=%h exp=0/100f0e0d0c0b0a09", rd_valid, rd_data); end
    rd_en = 1'b0;
    feed(8, 1'b0, to);
    wait_idle(dc, to);
    checks++; if (to !== 1'b0 || dc !== 1) begin failures++; $display("FAIL rdload_done to=%b pulses=%0d exp=0/1", to, dc); end
    rd(9'h030, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h5756555453525150) begin failures++; $display("FAIL rdload_rd_030 valid=%b data=%h exp=1/5756555453525150", v, d); end
  endtask

  task automatic test_reset_mid_load();
    bit to; int dc; logic [63:0] d; logic v;
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(8'h21 + i);
    start_load(9'h020, 10'd1);
    feed(8, 1'b0, to);
    wait_idle(dc, to);
    rd(9'h020, d, v);
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(8'hC0 + i);
    start_load(9'h020, 10'd2);
    feed(5, 1'b0, to);
    rst = 1'b1;
    tick();
    checks++; if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_err !== 1'b0) begin failures++; $display("FAIL midrst_flags busy=%b ready=%b done=%b err=%b exp=0", ld_busy, ld_ready, ld_done, ld_err); end
    checks++; if (ld_sum !== 8'h00 || rd_valid !== 1'b0 || rd_data !== 64'h0) begin failures++; $display("FAIL midrst_data sum=%h valid=%b data=%h exp=00/0/0", ld_sum, rd_valid, rd_data); end
    rst = 1'b0;
    tick();
    rd(9'h020, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h2827262524232221) begin failures++; $display("FAIL midrst_mem_020 valid=%b data=%h exp=1/2827262524232221", v, d); end
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(8'h31 + i);
    start_load(9'h020, 10'd1);
    feed(8, 1'b0, to);
    wait_idle(dc, to);
    checks++; if (to !== 1'b0 || dc !== 1 || ld_sum !== 8'hA4) begin failures++; $display("FAIL midrst_reload to=%b pulses=%0d sum=%h exp=0/1/a4", to, dc, ld_sum); end
    rd(9'h020, d, v);
    checks++; if (v !== 1'b1 || d !== 64'h3837363534333231) begin failures++; $display("FAIL midrst_new_020 valid=%b data=%h exp=1/3837363534333231", v, d); end
  endtask

  task automatic test_gaps();
    bit to; int dc; logic [63:0] d, exp_w; logic v; logic [7:0] exp_sum;
    logic [8:0] bases [2];
    bases[0] = 9'h040; bases[1] = 9'h080;
    exp_sum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      tb_bytes[i] = 8'(i * 7 + 3);
      exp_sum = exp_sum + tb_bytes[i];
    end
    for (int r = 0; r < 2; r++) begin
      start_load(bases[r], 10'd4);
      if (r == 1) begin
        ld_valid = 1'b0;
        repeat (5) tick();
        checks++; if (ld_busy !== 1'b1 || ld_ready !== 1'b1 || ld_sum !== 8'h00) begin failures++; $display("FAIL gap_stall busy=%b ready=%b sum=%h exp=1/1/00", ld_busy, ld_ready, ld_sum); end
      end
      feed(32, r == 1, to);
      wait_idle(dc, to);
      checks++; if (to !== 1'b0 || dc !== 1) begin failures++; $display("FAIL gap_done_%0d to=%b pulses=%0d exp=0/1", r, to, dc); end
      checks++; if (ld_sum !== exp_sum) begin failures++; $display("FAIL gap_sum_%0d got=%h exp=%h", r, ld_sum, exp_sum); end
      for (int w = 0; w < 4; w++) begin
        for (int b = 0; b < 8; b++) exp_w[8*b +: 8] = tb_bytes[8*w + b];
        rd(bases[r] + 9'(w), d, v);
        checks++; if (v !== 1'b1 || d !== exp_w) begin failures++; $display("FAIL gap_word_%0d_%0d valid=%b data=%h exp=1/%h", r, w, v, d, exp_w); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = 9'h000; ld_start = 1'b0; ld_base = 9'h000;
    ld_count = 10'd0; ld_byte = 8'h00; ld_valid = 1'b0;
    test_reset();
    test_basic_load();
    test_wrap();
    test_illegal_count();
    test_read_during_load();
    test_reset_mid_load();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
